// File: rtl/mem_stage.sv
// MIPS memory stage: dcache request/stall handshake, branch/jump redirect,
// MEM/WB pipeline register, sticky halt, access watchdog and access counters.
module mem_stage #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] m_npc,
  input  logic [25:0]       m_jaddr,
  input  logic [WORD_W-1:0] m_rdat1,
  input  logic [WORD_W-1:0] m_rdat2,
  input  logic [WORD_W-1:0] m_alu,
  input  logic [WORD_W-1:0] m_ext,
  input  logic              m_dren,
  input  logic              m_dwen,
  input  logic              m_memtoreg,
  input  logic              m_link,
  input  logic              m_regw,
  input  logic [4:0]        m_wsel,
  input  logic              m_branch,
  input  logic              m_bne,
  input  logic              m_zero,
  input  logic              m_jump,
  input  logic              m_jr,
  input  logic              m_halt,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              redirect,
  output logic [WORD_W-1:0] redirect_pc,
  output logic              wb_regw,
  output logic [4:0]        wb_wsel,
  output logic [WORD_W-1:0] wb_wdat,
  output logic              wb_halt,
  output logic              err,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state, next_state;
  logic [WCW-1:0] wcnt;
  logic           live;
  logic           req;
  logic           taken;
  logic [WORD_W-1:0] wdat_sel;

  // Requests and redirects vanish while reset is held so a lost access drops at once
  assign live      = nRST & !wb_halt;
  assign req       = (m_dren | m_dwen) & live;
  assign dmemREN   = m_dren & req;
  assign dmemWEN   = m_dwen & req;
  assign dmemaddr  = m_alu;
  assign dmemstore = m_rdat2;
  assign mem_stall = req & !dhit;
  assign taken     = m_branch & (m_zero ^ m_bne);

  always_comb begin
    wdat_sel = m_alu;
    if (m_memtoreg)  wdat_sel = dmemload;
    else if (m_link) wdat_sel = m_npc;
  end

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = m_npc;
    if (!mem_stall && live) begin
      if (m_jr) begin
        redirect    = 1'b1;
        redirect_pc = m_rdat1;
      end else if (m_jump) begin
        redirect    = 1'b1;
        redirect_pc = {m_npc[WORD_W-1 -: 4], m_jaddr, 2'b00};
      end else if (taken) begin
        redirect    = 1'b1;
        redirect_pc = m_npc + (m_ext << 2);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req && !dhit) next_state = WAIT;
      WAIT: if (dhit)         next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Watchdog only flags a stuck access; the access itself is never aborted
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wcnt <= '0;
      err  <= 1'b0;
    end else if (state == WAIT && !dhit) begin
      if (wcnt != WCW'(TIMEOUT)) wcnt <= wcnt + WCW'(1);
      if (wcnt >= WCW'(TIMEOUT - 1)) err <= 1'b1;
    end else if (next_state == IDLE) begin
      wcnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_regw <= 1'b0;
      wb_wsel <= '0;
      wb_wdat <= '0;
      wb_halt <= 1'b0;
    end else if (mem_stall) begin
      wb_regw <= 1'b0;
    end else begin
      wb_regw <= m_regw & !wb_halt;
      wb_wsel <= m_wsel;
      wb_wdat <= wdat_sel;
      if (m_halt) wb_halt <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (dhit && dmemREN) load_cnt  <= load_cnt + CNT_W'(1);
      if (dhit && dmemWEN) store_cnt <= store_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] m_npc, m_rdat1, m_rdat2, m_alu, m_ext, dmemload;
  logic [25:0] m_jaddr;
  logic        m_dren, m_dwen, m_memtoreg, m_link, m_regw;
  logic [4:0]  m_wsel;
  logic        m_branch, m_bne, m_zero, m_jump, m_jr, m_halt, dhit;
  logic        dmemREN, dmemWEN, mem_stall, redirect;
  logic [31:0] dmemaddr, dmemstore, redirect_pc, wb_wdat;
  logic        wb_regw, wb_halt, err;
  logic [4:0]  wb_wsel;
  logic [15:0] load_cnt, store_cnt;

  int total = 0;
  int bad   = 0;

  mem_stage #(.WORD_W(32), .TIMEOUT(4), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST),
    .m_npc(m_npc), .m_jaddr(m_jaddr), .m_rdat1(m_rdat1), .m_rdat2(m_rdat2),
    .m_alu(m_alu), .m_ext(m_ext), .m_dren(m_dren), .m_dwen(m_dwen),
    .m_memtoreg(m_memtoreg), .m_link(m_link), .m_regw(m_regw), .m_wsel(m_wsel),
    .m_branch(m_branch), .m_bne(m_bne), .m_zero(m_zero), .m_jump(m_jump),
    .m_jr(m_jr), .m_halt(m_halt), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .wb_regw(wb_regw), .wb_wsel(wb_wsel),
    .wb_wdat(wb_wdat), .wb_halt(wb_halt), .err(err),
    .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clearInputs();
    m_npc = '0; m_jaddr = '0; m_rdat1 = '0; m_rdat2 = '0; m_alu = '0;
    m_ext = '0; dmemload = '0; m_dren = 0; m_dwen = 0; m_memtoreg = 0;
    m_link = 0; m_regw = 0; m_wsel = '0; m_branch = 0; m_bne = 0;
    m_zero = 0; m_jump = 0; m_jr = 0; m_halt = 0; dhit = 0;
  endtask

  // Memory-side stimulus; control-flow fields are set directly by each test
  task automatic applyStimulus(input logic dren, input logic dwen,
                               input logic [31:0] addr, input logic [31:0] load,
                               input logic hit, input logic regw,
                               input logic [4:0] wsel);
    m_dren = dren; m_dwen = dwen; m_alu = addr; dmemload = load;
    dhit = hit; m_regw = regw; m_wsel = wsel; m_memtoreg = dren;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    clearInputs();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_wb_regw", {31'b0, wb_regw}, 32'd0);
    checkOutput("rst_wb_wdat", wb_wdat, 32'd0);
    checkOutput("rst_wb_halt", {31'b0, wb_halt}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_load_cnt", {16'b0, load_cnt}, 32'd0);
    nRST = 1'b1;
    tick();

    $display("[TB] lw with same-cycle hit");
    applyStimulus(1, 0, 32'h80, 32'hDEADBEEF, 1, 1, 5'd8);
    #1;
    checkOutput("lw_ren", {31'b0, dmemREN}, 32'd1);
    checkOutput("lw_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    checkOutput("lw_wb_regw", {31'b0, wb_regw}, 32'd1);
    checkOutput("lw_wb_wsel", {27'b0, wb_wsel}, 32'd8);
    checkOutput("lw_wb_wdat", wb_wdat, 32'hDEADBEEF);
    checkOutput("lw_load_cnt", {16'b0, load_cnt}, 32'd1);
    clearInputs();

    $display("[TB] sw with hit after 3 cycles");
    applyStimulus(0, 1, 32'h100, 32'h0, 0, 0, 5'd0);
    m_rdat2 = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("sw_wen", {31'b0, dmemWEN}, 32'd1);
      checkOutput("sw_addr", dmemaddr, 32'h100);
      checkOutput("sw_data", dmemstore, 32'h1234);
      checkOutput("sw_stall", {31'b0, mem_stall}, 32'd1);
      tick();
      checkOutput("sw_wb_regw", {31'b0, wb_regw}, 32'd0);
      checkOutput("sw_cnt_pending", {16'b0, store_cnt}, 32'd0);
    end
    dhit = 1;
    #1;
    checkOutput("sw_hit_stall", {31'b0, mem_stall}, 32'd0);
    checkOutput("sw_hit_addr", dmemaddr, 32'h100);
    tick();
    checkOutput("sw_store_cnt", {16'b0, store_cnt}, 32'd1);
    clearInputs();

    $display("[TB] branch and jr redirects");
    m_branch = 1; m_zero = 1; m_npc = 32'h40; m_ext = 32'hFFFFFFFE;
    #1;
    checkOutput("beq_redirect", {31'b0, redirect}, 32'd1);
    checkOutput("beq_pc", redirect_pc, 32'h38);
    m_bne = 1;
    #1;
    checkOutput("bne_redirect", {31'b0, redirect}, 32'd0);
    checkOutput("bne_pc", redirect_pc, 32'h40);
    m_branch = 0; m_bne = 0; m_jr = 1; m_jump = 1;
    m_rdat1 = 32'h200; m_jaddr = 26'h3;
    #1;
    checkOutput("jr_redirect", {31'b0, redirect}, 32'd1);
    checkOutput("jr_pc", redirect_pc, 32'h200);
    clearInputs();

    $display("[TB] jal link");
    m_jump = 1; m_jaddr = 26'h40; m_link = 1; m_regw = 1; m_wsel = 5'd31;
    m_npc = 32'h1004; m_alu = 32'h55;
    #1;
    checkOutput("jal_redirect", {31'b0, redirect}, 32'd1);
    checkOutput("jal_pc", redirect_pc, 32'h100);
    tick();
    checkOutput("jal_wb_wdat", wb_wdat, 32'h1004);
    checkOutput("jal_wb_wsel", {27'b0, wb_wsel}, 32'd31);
    checkOutput("jal_wb_regw", {31'b0, wb_regw}, 32'd1);
    clearInputs();

    $display("[TB] watchdog on withheld hit");
    applyStimulus(1, 0, 32'h300, 32'hCAFE0001, 0, 1, 5'd5);
    repeat (2) tick();
    checkOutput("wd_err_early", {31'b0, err}, 32'd0);
    repeat (8) tick();
    checkOutput("wd_err_set", {31'b0, err}, 32'd1);
    checkOutput("wd_still_stall", {31'b0, mem_stall}, 32'd1);
    checkOutput("wd_wb_regw", {31'b0, wb_regw}, 32'd0);
    dhit = 1;
    tick();
    clearInputs();
    checkOutput("wd_err_sticky", {31'b0, err}, 32'd1);
    checkOutput("wd_load_cnt", {16'b0, load_cnt}, 32'd2);
    checkOutput("wd_wb_wdat", wb_wdat, 32'hCAFE0001);
    checkOutput("wd_wb_regw_done", {31'b0, wb_regw}, 32'd1);
    tick();
    checkOutput("wd_err_hold", {31'b0, err}, 32'd1);

    $display("[TB] reset during a pending access");
    applyStimulus(1, 0, 32'h400, 32'h11111111, 0, 1, 5'd6);
    repeat (2) tick();
    nRST = 1'b0;
    #1;
    checkOutput("rmw_ren", {31'b0, dmemREN}, 32'd0);
    checkOutput("rmw_stall", {31'b0, mem_stall}, 32'd0);
    checkOutput("rmw_err", {31'b0, err}, 32'd0);
    checkOutput("rmw_load_cnt", {16'b0, load_cnt}, 32'd0);
    checkOutput("rmw_store_cnt", {16'b0, store_cnt}, 32'd0);
    checkOutput("rmw_wb_wdat", wb_wdat, 32'd0);
    clearInputs();
    #1;
    nRST = 1'b1;
    tick();
    checkOutput("rmw_no_wb", {31'b0, wb_regw}, 32'd0);
    applyStimulus(1, 0, 32'h404, 32'h22222222, 1, 1, 5'd7);
    #1;
    checkOutput("rmw_idle_nostall", {31'b0, mem_stall}, 32'd0);
    tick();
    clearInputs();
    checkOutput("rmw_cnt_restart", {16'b0, load_cnt}, 32'd1);
    checkOutput("rmw_wb_wdat2", wb_wdat, 32'h22222222);

    $display("[TB] halt blocks later work");
    m_halt = 1;
    tick();
    checkOutput("halt_set", {31'b0, wb_halt}, 32'd1);
    m_halt = 0;
    applyStimulus(1, 0, 32'h500, 32'h33333333, 1, 1, 5'd9);
    m_branch = 1; m_zero = 1; m_npc = 32'h80;
    #1;
    checkOutput("halt_no_ren", {31'b0, dmemREN}, 32'd0);
    checkOutput("halt_no_stall", {31'b0, mem_stall}, 32'd0);
    checkOutput("halt_no_redirect", {31'b0, redirect}, 32'd0);
    tick();
    checkOutput("halt_no_regw", {31'b0, wb_regw}, 32'd0);
    checkOutput("halt_sticky", {31'b0, wb_halt}, 32'd1);
    checkOutput("halt_load_cnt", {16'b0, load_cnt}, 32'd1);
    clearInputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
